// File: rtl/uart_txrx.sv
// 8N1 UART: independent transmitter and receiver sharing one clock, one reset and one baud divisor.
// Serial frame: start bit (0), eight data bits LSB first, stop bit (1).
module uart_txrx #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Active,
   output logic       o_TX_Serial,
   output logic       o_TX_Done,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_t;

   state_t           r_tx_state;
   logic [CNT_W-1:0] r_tx_count;
   logic [2:0]       r_tx_index;
   logic [7:0]       r_tx_data;

   state_t           r_rx_state;
   logic [CNT_W-1:0] r_rx_count;
   logic [2:0]       r_rx_index;
   logic [7:0]       r_rx_shift;
   logic             r_rx_sync_p0;
   logic             r_rx_sync_p1;

   // Transmitter: the line value for the next bit is registered on the edge that ends the current one
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_tx_state  <= S_IDLE;
         r_tx_count  <= '0;
         r_tx_index  <= '0;
         o_TX_Serial <= 1'b1;
         o_TX_Active <= 1'b0;
         o_TX_Done   <= 1'b0;
      end else begin
         case (r_tx_state)
            S_IDLE: begin
               o_TX_Serial <= 1'b1;
               o_TX_Done   <= 1'b0;
               r_tx_count  <= '0;
               r_tx_index  <= '0;
               if (i_TX_DV) begin
                  r_tx_data   <= i_TX_Byte;
                  o_TX_Active <= 1'b1;
                  o_TX_Serial <= 1'b0;
                  r_tx_state  <= S_START;
               end
            end
            S_START: begin
               if (r_tx_count == BIT_LAST) begin
                  r_tx_count  <= '0;
                  o_TX_Serial <= r_tx_data[0];
                  r_tx_state  <= S_DATA;
               end else begin
                  r_tx_count <= r_tx_count + CNT_ONE;
               end
            end
            S_DATA: begin
               if (r_tx_count == BIT_LAST) begin
                  r_tx_count <= '0;
                  if (r_tx_index == 3'd7) begin
                     r_tx_index  <= '0;
                     o_TX_Serial <= 1'b1;
                     r_tx_state  <= S_STOP;
                  end else begin
                     r_tx_index  <= r_tx_index + 3'd1;
                     o_TX_Serial <= r_tx_data[r_tx_index + 3'd1];
                  end
               end else begin
                  r_tx_count <= r_tx_count + CNT_ONE;
               end
            end
            S_STOP: begin
               if (r_tx_count == BIT_LAST) begin
                  r_tx_count  <= '0;
                  o_TX_Done   <= 1'b1;
                  o_TX_Active <= 1'b0;
                  r_tx_state  <= S_CLEANUP;
               end else begin
                  r_tx_count <= r_tx_count + CNT_ONE;
               end
            end
            S_CLEANUP: begin
               o_TX_Done  <= 1'b0;
               r_tx_state <= S_IDLE;
            end
            default: r_tx_state <= S_IDLE;
         endcase
      end
   end

   // Two-flop synchroniser on the asynchronous line, idling high
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_rx_sync_p0 <= 1'b1;
         r_rx_sync_p1 <= 1'b1;
      end else begin
         r_rx_sync_p0 <= i_RX_Serial;
         r_rx_sync_p1 <= r_rx_sync_p0;
      end
   end

   // Receiver: confirm the start bit at its centre, then sample every full bit period from there
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_rx_state <= S_IDLE;
         r_rx_count <= '0;
         r_rx_index <= '0;
         o_RX_DV    <= 1'b0;
         o_RX_Byte  <= '0;
      end else begin
         case (r_rx_state)
            S_IDLE: begin
               o_RX_DV    <= 1'b0;
               r_rx_count <= '0;
               r_rx_index <= '0;
               if (!r_rx_sync_p1) r_rx_state <= S_START;
            end
            S_START: begin
               if (r_rx_count == HALF_BIT) begin
                  r_rx_count <= '0;
                  r_rx_state <= r_rx_sync_p1 ? S_IDLE : S_DATA;
               end else begin
                  r_rx_count <= r_rx_count + CNT_ONE;
               end
            end
            S_DATA: begin
               if (r_rx_count == BIT_LAST) begin
                  r_rx_count             <= '0;
                  r_rx_shift[r_rx_index] <= r_rx_sync_p1;
                  if (r_rx_index == 3'd7) begin
                     r_rx_index <= '0;
                     r_rx_state <= S_STOP;
                  end else begin
                     r_rx_index <= r_rx_index + 3'd1;
                  end
               end else begin
                  r_rx_count <= r_rx_count + CNT_ONE;
               end
            end
            S_STOP: begin
               if (r_rx_count == BIT_LAST) begin
                  r_rx_count <= '0;
                  r_rx_state <= S_CLEANUP;
                  if (r_rx_sync_p1) begin
                     o_RX_Byte <= r_rx_shift;
                     o_RX_DV   <= 1'b1;
                  end
               end else begin
                  r_rx_count <= r_rx_count + CNT_ONE;
               end
            end
            S_CLEANUP: begin
               o_RX_DV    <= 1'b0;
               r_rx_state <= S_IDLE;
            end
            default: r_rx_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: frame-level TX model and RX byte scoreboard checked every cycle,
// plus hand-computed literals for bit order, frame length, glitch, framing error and reset.
module tb_uart_txrx;

   localparam int CPB   = 217;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       i_Reset;
   logic       i_TX_DV;
   logic [7:0] i_TX_Byte;
   logic       o_TX_Active;
   logic       o_TX_Serial;
   logic       o_TX_Done;
   logic       i_RX_Serial;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;

   logic       rx_lb  = 1'b1;
   logic       rx_drv = 1'b1;

   int         checks = 0;
   int         errors = 0;
   bit         chk_en = 1'b0;

   int         tx_t = -1;
   logic [9:0] tx_frame = '1;
   logic [7:0] exp_q[$];
   logic [7:0] model_rx = '0;
   int         drv_seq = 0;
   int         seen_seq = 0;
   logic [7:0] drv_byte = '0;

   int         act, dn, dvn;
   logic [7:0] dvb;
   logic [9:0] a5_got;

   always #20 clk = ~clk;

   assign i_RX_Serial = rx_lb ? (o_TX_Active ? o_TX_Serial : 1'b1) : rx_drv;

   uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock    (clk),
      .i_Reset    (i_Reset),
      .i_TX_DV    (i_TX_DV),
      .i_TX_Byte  (i_TX_Byte),
      .o_TX_Active(o_TX_Active),
      .o_TX_Serial(o_TX_Serial),
      .o_TX_Done  (o_TX_Done),
      .i_RX_Serial(i_RX_Serial),
      .o_RX_DV    (o_RX_DV),
      .o_RX_Byte  (o_RX_Byte)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Model: tx_t counts cycles since the frame was accepted; RX expectations are a queue of bytes
   always @(posedge clk) begin
      if (o_RX_DV === 1'b1 && exp_q.size() > 0) model_rx = exp_q.pop_front();
      if (drv_seq != seen_seq) begin
         seen_seq = drv_seq;
         exp_q.push_back(drv_byte);
      end
      if (i_Reset) begin
         tx_t = -1;
         exp_q.delete();
         model_rx = '0;
      end else if (tx_t < 0 || tx_t == FRAME + 1) begin
         if (i_TX_DV) begin
            tx_t = 0;
            tx_frame = {1'b1, i_TX_Byte, 1'b0};
            if (rx_lb) exp_q.push_back(i_TX_Byte);
         end else begin
            tx_t = -1;
         end
      end else begin
         tx_t++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_act;
         exp_act = (tx_t >= 0 && tx_t < FRAME);
         chk("tx_active", o_TX_Active, exp_act);
         chk("tx_serial", o_TX_Serial, exp_act ? tx_frame[tx_t / CPB] : 1'b1);
         chk("tx_done", o_TX_Done, (tx_t == FRAME));
         if (o_RX_DV !== 1'b1)     chk("rx_byte_hold", o_RX_Byte, model_rx);
         else if (exp_q.size() == 0) chk("rx_dv_spurious", o_RX_DV, 1'b0);
         else                      chk("rx_byte_at_dv", o_RX_Byte, exp_q[0]);
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      i_TX_DV   = 1'b1;
      i_TX_Byte = b;
      @(negedge clk);
      i_TX_DV   = 1'b0;
   endtask

   // Returns on the negedge of the cycle in which o_TX_Done is high, or after the bound
   task automatic watch(output int a, output int d, output int v, output logic [7:0] vb);
      a = 0; d = 0; v = 0; vb = '0;
      for (int i = 0; i < FRAME + 100; i++) begin
         if (o_TX_Active) a++;
         if (o_RX_DV) begin
            v++;
            vb = o_RX_Byte;
         end
         if (o_TX_Done) begin
            d++;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 2 * CPB && exp_q.size() != 0; i++) @(negedge clk);
      chk(name, exp_q.size(), 0);
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      drv_byte = b;
      if (stop) drv_seq++;
      for (int k = 0; k < 10; k++) begin
         rx_drv = f[k];
         repeat (CPB) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   initial begin
      i_Reset   = 1'b1;
      i_TX_DV   = 1'b0;
      i_TX_Byte = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_tx_serial", o_TX_Serial, 1'b1);
      chk("rst_tx_active", o_TX_Active, 1'b0);
      chk("rst_tx_done", o_TX_Done, 1'b0);
      chk("rst_rx_dv", o_RX_DV, 1'b0);
      chk("rst_rx_byte", o_RX_Byte, 8'h00);
      i_Reset = 1'b0;
      repeat (5) @(negedge clk);

      send(8'h3F);
      watch(act, dn, dvn, dvb);
      chk("lb3f_active_cycles", act, 2170);
      chk("lb3f_done_pulses", dn, 1);
      chk("lb3f_dv_pulses", dvn, 1);
      chk("lb3f_rx_byte", dvb, 8'h3F);
      drain("lb3f_drained");

      send(8'hA5);
      repeat (CPB / 2) @(negedge clk);
      a5_got[0] = o_TX_Serial;
      for (int k = 1; k < 10; k++) begin
         repeat (CPB) @(negedge clk);
         a5_got[k] = o_TX_Serial;
      end
      chk("a5_bit_order", a5_got, 10'b1101001010);
      watch(act, dn, dvn, dvb);
      chk("a5_done_pulses", dn, 1);
      drain("a5_drained");
      chk("a5_rx_byte", o_RX_Byte, 8'hA5);

      send(8'h00);
      watch(act, dn, dvn, dvb);
      chk("lb00_dv_pulses", dvn, 1);
      chk("lb00_rx_byte", dvb, 8'h00);
      drain("lb00_drained");
      send(8'hFF);
      watch(act, dn, dvn, dvb);
      chk("lbff_dv_pulses", dvn, 1);
      chk("lbff_rx_byte", dvb, 8'hFF);
      drain("lbff_drained");

      send(8'h12);
      repeat (1000) @(negedge clk);
      send(8'h34);
      watch(act, dn, dvn, dvb);
      chk("busy_first_dv", dvn, 1);
      chk("busy_first_byte", dvb, 8'h12);
      send(8'h56);
      watch(act, dn, dvn, dvb);
      chk("b2b_active_cycles", act, 2170);
      chk("b2b_dv", dvn, 1);
      chk("b2b_byte", dvb, 8'h56);
      drain("b2b_drained");

      repeat (5) @(negedge clk);
      rx_lb  = 1'b0;
      rx_drv = 1'b0;
      repeat (50) @(negedge clk);
      rx_drv = 1'b1;
      repeat (300) @(negedge clk);
      chk("glitch_byte_held", o_RX_Byte, 8'h56);
      drive_frame(8'hC3, 1'b1);
      drain("c3_drained");
      chk("c3_rx_byte", o_RX_Byte, 8'hC3);

      drive_frame(8'h77, 1'b0);
      repeat (400) @(negedge clk);
      chk("framing_byte_held", o_RX_Byte, 8'hC3);

      rx_lb = 1'b1;
      repeat (5) @(negedge clk);
      send(8'h3F);
      repeat (4 * CPB) @(negedge clk);
      i_Reset = 1'b1;
      @(negedge clk);
      i_Reset = 1'b0;
      chk("midrst_tx_serial", o_TX_Serial, 1'b1);
      chk("midrst_tx_active", o_TX_Active, 1'b0);
      chk("midrst_rx_byte", o_RX_Byte, 8'h00);
      watch(act, dn, dvn, dvb);
      chk("midrst_no_active", act, 0);
      chk("midrst_no_done", dn, 0);
      chk("midrst_no_dv", dvn, 0);

      send(8'h3F);
      watch(act, dn, dvn, dvb);
      chk("post_rst_active_cycles", act, 2170);
      chk("post_rst_done", dn, 1);
      chk("post_rst_rx_byte", dvb, 8'h3F);
      drain("post_rst_drained");

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
